// File: rtl/uoram_datapath_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uoram_datapath_mc_pkg
// Description : Shared encodings and derivations for the multi-channel
//               unified-ORAM frontend data path.
// Revision    : 1.0  initial release
// ============================================================================
package uoram_datapath_mc_pkg;

    localparam logic [1:0] c_KindPosMap = 2'd0;
    localparam logic [1:0] c_KindRead   = 2'd1;
    localparam logic [1:0] c_KindWrite  = 2'd2;
    localparam logic [1:0] c_KindFake   = 2'd3;

    // Widest chunk the fake-data builder can produce; callers truncate.
    localparam int c_FakeMaxW = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PMAP  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FAKE  = 3'd4
    } state_t;

    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    function automatic int leafInBlock(input int bChunks, input int fedWidth, input int leafWidth);
        return (bChunks * fedWidth) / leafWidth;
    endfunction

    function automatic logic [c_FakeMaxW-1:0] fakeData(input logic [31:0] pattern);
        logic [c_FakeMaxW-1:0] w_word;
        for (int i = 0; i < c_FakeMaxW / 32; i++) begin
            w_word[i*32 +: 32] = pattern;
        end
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uoram_datapath_mc_funnel.sv
`default_nettype none
// ============================================================================
// Module      : uoram_width_funnel
// Description : Ready/valid width converter, IWidth -> OWidth, LSB-first in
//               both the packing and the unpacking direction.
// Revision    : 1.0  initial release
// ============================================================================
module uoram_width_funnel #(
    parameter int IWidth = 64,
    parameter int OWidth = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [IWidth-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [OWidth-1:0] OutData
);

    generate
        if (IWidth >= OWidth) begin : g_unpack
            localparam int c_Ratio = IWidth / OWidth;
            localparam int c_CntW  = $clog2(c_Ratio + 1);

            logic [IWidth-1:0] r_buf;
            logic [c_CntW-1:0] r_cnt;

            assign InReady  = (r_cnt == '0);
            assign OutValid = (r_cnt != '0);
            assign OutData  = r_buf[OWidth-1:0];

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end else if (InValid && InReady) begin
                    r_buf <= InData;
                    r_cnt <= c_CntW'(c_Ratio);
                end else if (OutValid && OutReady) begin
                    r_buf <= r_buf >> OWidth;
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end else begin : g_pack
            localparam int c_Ratio = OWidth / IWidth;
            localparam int c_CntW  = $clog2(c_Ratio + 1);

            logic [OWidth-1:0] r_buf;
            logic [c_CntW-1:0] r_cnt;
            logic [OWidth-1:0] w_ext;

            // New words enter at the top and shift down, so the first lands in the LSBs.
            assign w_ext    = OWidth'(InData);
            assign InReady  = (r_cnt != c_CntW'(c_Ratio));
            assign OutValid = (r_cnt == c_CntW'(c_Ratio));
            assign OutData  = r_buf;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end else if (InValid && InReady) begin
                    r_buf <= (r_buf >> IWidth) | (w_ext << (OWidth - IWidth));
                    r_cnt <= r_cnt + 1'b1;
                end else if (OutValid && OutReady) begin
                    r_cnt <= '0;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uoram_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : uoram_datapath_mc
// Description : Unified-ORAM frontend data path steering backend chunks to a
//               selected client channel or to the PLB evict/refill funnels.
// Revision    : 1.0  initial release
// ============================================================================
module uoram_datapath_mc
    import uoram_datapath_mc_pkg::*;
#(
    parameter  int          FEDWidth    = 64,
    parameter  int          LeafWidth   = 32,
    parameter  int          BChunks     = 8,
    parameter  int          NumCh       = 4,
    parameter  logic [31:0] FakePattern = 32'hDEADBEEF,
    localparam int          ChW         = chWidth(NumCh),
    localparam int          LeafInBlock = leafInBlock(BChunks, FEDWidth, LeafWidth)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      SwitchReq,
    input  logic [1:0]                ReqKind,
    input  logic [ChW-1:0]            ReqCh,
    output logic                      Busy,
    output logic                      Error,
    input  logic [NumCh-1:0]          ChInValid,
    output logic [NumCh-1:0]          ChInReady,
    input  logic [NumCh*FEDWidth-1:0] ChInData,
    output logic [NumCh-1:0]          ChRetValid,
    input  logic [NumCh-1:0]          ChRetReady,
    output logic [FEDWidth-1:0]       ChRetData,
    input  logic                      EvictValid,
    input  logic [LeafWidth-1:0]      EvictData,
    output logic                      EvictEmpty,
    output logic                      RefillValid,
    input  logic                      RefillReady,
    output logic [LeafWidth-1:0]      RefillData,
    output logic                      StoreValid,
    input  logic                      StoreReady,
    output logic [FEDWidth-1:0]       StoreData,
    input  logic                      LoadValid,
    output logic                      LoadReady,
    input  logic [FEDWidth-1:0]       LoadData
);

    localparam int                  c_CntW = $clog2(BChunks + 1);
    localparam int                  c_PtrW = $clog2(LeafInBlock);
    localparam int                  c_OccW = $clog2(LeafInBlock + 1);
    localparam logic [c_CntW-1:0]   c_Full = c_CntW'(BChunks);
    localparam logic [FEDWidth-1:0] c_Fake = FEDWidth'(fakeData(FakePattern));

    state_t              r_state, w_nextState;
    logic [ChW-1:0]      r_ch;
    logic [c_CntW-1:0]   r_stCnt, r_ldCnt;
    logic                r_error;
    logic                w_stOpen, w_ldOpen, w_done, w_errSet;
    logic                w_storeFire, w_ldFire;
    logic [NumCh-1:0]    w_chSel;
    logic [FEDWidth-1:0] w_chData;

    // Evict staging register and FIFO
    logic                 r_evValid;
    logic [LeafWidth-1:0] r_evData;
    logic [LeafWidth-1:0] r_mem [LeafInBlock];
    logic [c_PtrW-1:0]    r_wrPtr, r_rdPtr;
    logic [c_OccW-1:0]    r_occ;
    logic                 w_fifoFull, w_fifoEmpty, w_push, w_pop, w_dropLeaf;

    logic                w_evFunInValid, w_evFunInReady, w_evFunValid, w_evFunOutReady;
    logic [FEDWidth-1:0] w_evFunData;
    logic                w_refInValid, w_refInReady;

    assign w_stOpen = (r_stCnt < c_Full);
    assign w_ldOpen = (r_ldCnt < c_Full);
    assign w_chSel  = NumCh'(1) << r_ch;
    assign w_chData = ChInData[r_ch*FEDWidth +: FEDWidth];

    assign Busy       = (r_state != ST_IDLE);
    assign Error      = r_error;
    assign EvictEmpty = w_fifoEmpty;

    always_comb begin
        w_nextState = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (SwitchReq) begin
                    case (ReqKind)
                        c_KindPosMap: w_nextState = ST_PMAP;
                        c_KindRead:   w_nextState = ST_READ;
                        c_KindWrite:  w_nextState = ST_WRITE;
                        default:      w_nextState = ST_FAKE;
                    endcase
                end
            end
            ST_PMAP:  w_done = !w_stOpen && !w_ldOpen;
            ST_READ:  w_done = !w_ldOpen;
            ST_WRITE: w_done = !w_stOpen;
            ST_FAKE:  w_done = !w_stOpen && !w_ldOpen;
            default:  w_nextState = ST_IDLE;
        endcase
        if (w_done) begin
            w_nextState = ST_IDLE;
        end
    end

    // Every valid is gated by its counter, so counts saturate at BChunks.
    always_comb begin
        StoreValid      = 1'b0;
        StoreData       = '0;
        LoadReady       = 1'b0;
        ChInReady       = '0;
        ChRetValid      = '0;
        ChRetData       = '0;
        w_evFunOutReady = 1'b0;
        w_refInValid    = 1'b0;
        w_ldFire        = 1'b0;
        case (r_state)
            ST_PMAP: begin
                StoreValid      = w_evFunValid && w_stOpen;
                StoreData       = w_evFunData;
                w_evFunOutReady = StoreReady && w_stOpen;
                LoadReady       = w_refInReady && w_ldOpen;
                w_refInValid    = LoadValid && w_ldOpen;
                w_ldFire        = LoadValid && LoadReady;
            end
            ST_READ: begin
                ChRetValid = w_chSel & {NumCh{LoadValid && w_ldOpen}};
                ChRetData  = LoadData;
                LoadReady  = ChRetReady[r_ch] && w_ldOpen;
                w_ldFire   = LoadValid && LoadReady;
            end
            ST_WRITE: begin
                StoreValid = ChInValid[r_ch] && w_stOpen;
                StoreData  = w_chData;
                ChInReady  = w_chSel & {NumCh{StoreReady && w_stOpen}};
            end
            ST_FAKE: begin
                StoreValid = w_stOpen;
                StoreData  = c_Fake;
                ChRetValid = w_chSel & {NumCh{w_ldOpen}};
                ChRetData  = c_Fake;
                w_ldFire   = w_ldOpen && ChRetReady[r_ch];
            end
            default: ;
        endcase
    end

    assign w_storeFire = StoreValid && StoreReady;

    assign w_errSet = (SwitchReq && (r_state != ST_IDLE)) || w_dropLeaf ||
                      (LoadValid && ((r_state == ST_IDLE) || (r_state == ST_WRITE) || (r_state == ST_FAKE))) ||
                      (LoadValid && ((r_state == ST_READ) || (r_state == ST_PMAP)) && !w_ldOpen);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_stCnt <= '0;
            r_ldCnt <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_error <= r_error | w_errSet;
            if ((r_state == ST_IDLE) && SwitchReq) begin
                r_ch <= ReqCh;
            end
            if (w_done) begin
                r_stCnt <= '0;
                r_ldCnt <= '0;
            end else begin
                if (w_storeFire) r_stCnt <= r_stCnt + 1'b1;
                if (w_ldFire)    r_ldCnt <= r_ldCnt + 1'b1;
            end
        end
    end

    // Leaves only drain into the funnel during PMAP, so the FIFO alone bounds capacity.
    assign w_fifoFull     = (r_occ == c_OccW'(LeafInBlock));
    assign w_fifoEmpty    = (r_occ == '0);
    assign w_push         = r_evValid && !w_fifoFull;
    assign w_dropLeaf     = r_evValid && w_fifoFull;
    assign w_evFunInValid = !w_fifoEmpty && (r_state == ST_PMAP);
    assign w_pop          = w_evFunInValid && w_evFunInReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_evValid <= 1'b0;
            r_evData  <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_occ     <= '0;
        end else begin
            r_evValid <= EvictValid;
            r_evData  <= EvictData;
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == c_PtrW'(LeafInBlock - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == c_PtrW'(LeafInBlock - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_evData;
        end
    end

    uoram_width_funnel #(
        .IWidth (LeafWidth),
        .OWidth (FEDWidth)
    ) u_evictFunnel (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (w_evFunInValid),
        .InReady  (w_evFunInReady),
        .InData   (r_mem[r_rdPtr]),
        .OutValid (w_evFunValid),
        .OutReady (w_evFunOutReady),
        .OutData  (w_evFunData)
    );

    uoram_width_funnel #(
        .IWidth (FEDWidth),
        .OWidth (LeafWidth)
    ) u_refillFunnel (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (w_refInValid),
        .InReady  (w_refInReady),
        .InData   (LoadData),
        .OutValid (RefillValid),
        .OutReady (RefillReady),
        .OutData  (RefillData)
    );

endmodule
`default_nettype wire

// File: tb/tb_uoram_datapath_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_uoram_datapath_mc
// Description : Directed self-checking bench for uoram_datapath_mc.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uoram_datapath_mc;

    localparam int FW = 64;
    localparam int LW = 32;
    localparam int NC = 4;
    localparam logic [63:0] c_Fake = 64'hDEADBEEF_DEADBEEF;

    logic           Clock, Reset;
    logic           SwitchReq;
    logic [1:0]     ReqKind;
    logic [1:0]     ReqCh;
    logic           Busy, Error;
    logic [NC-1:0]  ChInValid, ChInReady, ChRetValid, ChRetReady;
    logic [NC*FW-1:0] ChInData;
    logic [FW-1:0]  ChRetData;
    logic           EvictValid, EvictEmpty;
    logic [LW-1:0]  EvictData;
    logic           RefillValid, RefillReady;
    logic [LW-1:0]  RefillData;
    logic           StoreValid, StoreReady;
    logic [FW-1:0]  StoreData;
    logic           LoadValid, LoadReady;
    logic [FW-1:0]  LoadData;

    int checks   = 0;
    int failures = 0;

    uoram_datapath_mc u_dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SwitchReq   (SwitchReq),
        .ReqKind     (ReqKind),
        .ReqCh       (ReqCh),
        .Busy        (Busy),
        .Error       (Error),
        .ChInValid   (ChInValid),
        .ChInReady   (ChInReady),
        .ChInData    (ChInData),
        .ChRetValid  (ChRetValid),
        .ChRetReady  (ChRetReady),
        .ChRetData   (ChRetData),
        .EvictValid  (EvictValid),
        .EvictData   (EvictData),
        .EvictEmpty  (EvictEmpty),
        .RefillValid (RefillValid),
        .RefillReady (RefillReady),
        .RefillData  (RefillData),
        .StoreValid  (StoreValid),
        .StoreReady  (StoreReady),
        .StoreData   (StoreData),
        .LoadValid   (LoadValid),
        .LoadReady   (LoadReady),
        .LoadData    (LoadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idleInputs();
        SwitchReq   = 1'b0;
        ReqKind     = 2'd0;
        ReqCh       = 2'd0;
        ChInValid   = '0;
        ChInData    = '0;
        ChRetReady  = '0;
        EvictValid  = 1'b0;
        EvictData   = '0;
        RefillReady = 1'b0;
        StoreReady  = 1'b0;
        LoadValid   = 1'b0;
        LoadData    = '0;
    endtask

    task automatic applyReset();
        @(negedge Clock);
        Reset = 1'b0;
        idleInputs();
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic startReq(input logic [1:0] kind, input logic [1:0] ch);
        @(negedge Clock);
        SwitchReq = 1'b1;
        ReqKind   = kind;
        ReqCh     = ch;
        @(posedge Clock);
        #1 SwitchReq = 1'b0;
    endtask

    task automatic doWrite(input int ch, input int n);
        int idx = 0;
        for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
            @(negedge Clock);
            for (int i = 0; i < NC; i++) ChInData[i*FW +: FW] = 64'hBAD0 + 64'(i);
            ChInData[ch*FW +: FW] = 64'(idx + 1);
            ChInValid  = 4'b0001 << ch;
            StoreReady = 1'($urandom_range(0, 1));
            #1;
            checkValue("wr_other_ready", 64'(ChInReady & ~(4'b0001 << ch)), 64'd0);
            if (StoreValid && StoreReady) begin
                checkValue("wr_data", StoreData, 64'(idx + 1));
                idx++;
            end
        end
        checkValue("wr_count", 64'(idx), 64'(n));
    endtask

    task automatic writeTail();
        @(negedge Clock);
        StoreReady = 1'b1;
        #1;
        checkValue("wr_busy_hold", 64'(Busy), 64'd1);
        checkValue("wr_store_gated", 64'(StoreValid), 64'd0);
        @(negedge Clock);
        ChInValid  = '0;
        StoreReady = 1'b0;
        #1;
        checkValue("wr_busy_fall", 64'(Busy), 64'd0);
    endtask

    task automatic doRead(input int ch, input bit withSwitch, input logic expErr);
        int idx = 0;
        logic [NC-1:0] mask;
        mask = 4'b0001 << ch;
        startReq(2'd1, 2'(ch));
        for (int cyc = 0; cyc < 200 && idx < 8; cyc++) begin
            @(negedge Clock);
            LoadValid  = 1'b1;
            LoadData   = 64'h1111_2222_0000_0000 + 64'(idx);
            ChRetReady = ((cyc % 2) == 1) ? mask : 4'b0000;
            SwitchReq  = withSwitch && (cyc == 3);
            ReqKind    = 2'd2;
            ReqCh      = 2'd0;
            #1;
            checkValue("rd_valid", 64'(ChRetValid), 64'(mask));
            checkValue("rd_load_ready", 64'(LoadReady), 64'(ChRetReady[ch]));
            if (LoadReady) begin
                checkValue("rd_data", ChRetData, 64'h1111_2222_0000_0000 + 64'(idx));
                idx++;
            end
        end
        checkValue("rd_count", 64'(idx), 64'd8);
        @(negedge Clock);
        SwitchReq  = 1'b0;
        LoadValid  = 1'b0;
        ChRetReady = '0;
        #1;
        checkValue("rd_busy_hold", 64'(Busy), 64'd1);
        @(negedge Clock);
        #1;
        checkValue("rd_busy_fall", 64'(Busy), 64'd0);
        checkValue("rd_error", 64'(Error), 64'(expErr));
    endtask

    task automatic sendLeaves(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            EvictValid = 1'b1;
            EvictData  = 32'(base + i);
        end
        @(negedge Clock);
        EvictValid = 1'b0;
        @(negedge Clock);
    endtask

    task automatic doPmap(input int base);
        int st = 0;
        int ld = 0;
        int rf = 0;
        startReq(2'd0, 2'd0);
        for (int cyc = 0; cyc < 400 && !(st == 8 && ld == 8 && rf == 16); cyc++) begin
            @(negedge Clock);
            StoreReady  = 1'b1;
            RefillReady = 1'b1;
            LoadValid   = (ld < 8);
            LoadData    = {32'(32'h2000_0000 + 2*ld + 1), 32'(32'h2000_0000 + 2*ld)};
            #1;
            if (StoreValid && StoreReady) begin
                checkValue("pm_store", StoreData, {32'(base + 2*st + 1), 32'(base + 2*st)});
                st++;
            end
            if (LoadValid && LoadReady) ld++;
            if (RefillValid && RefillReady) begin
                checkValue("pm_refill", 64'(RefillData), 64'(32'h2000_0000 + rf));
                rf++;
            end
        end
        checkValue("pm_stores", 64'(st), 64'd8);
        checkValue("pm_loads", 64'(ld), 64'd8);
        checkValue("pm_refills", 64'(rf), 64'd16);
        @(negedge Clock);
        StoreReady  = 1'b0;
        RefillReady = 1'b0;
        LoadValid   = 1'b0;
        @(negedge Clock);
        #1;
        checkValue("pm_busy_fall", 64'(Busy), 64'd0);
        checkValue("pm_evict_empty", 64'(EvictEmpty), 64'd1);
    endtask

    task automatic doFake();
        int st = 0;
        int rt = 0;
        startReq(2'd3, 2'd3);
        for (int cyc = 0; cyc < 100 && st < 8; cyc++) begin
            @(negedge Clock);
            ChRetReady = 4'b1000;
            StoreReady = (cyc >= 20);
            #1;
            if (cyc == 19) begin
                checkValue("fk_ret_first", 64'(rt), 64'd8);
                checkValue("fk_no_store", 64'(st), 64'd0);
                checkValue("fk_busy", 64'(Busy), 64'd1);
            end
            checkValue("fk_load_ready", 64'(LoadReady), 64'd0);
            checkValue("fk_other_valid", 64'(ChRetValid & 4'b0111), 64'd0);
            if (ChRetValid[3] && ChRetReady[3]) begin
                checkValue("fk_ret_data", ChRetData, c_Fake);
                rt++;
            end
            if (StoreValid && StoreReady) begin
                checkValue("fk_store_data", StoreData, c_Fake);
                st++;
            end
        end
        checkValue("fk_stores", 64'(st), 64'd8);
        checkValue("fk_returns", 64'(rt), 64'd8);
        @(negedge Clock);
        StoreReady = 1'b0;
        ChRetReady = '0;
        #1;
        checkValue("fk_busy_hold", 64'(Busy), 64'd1);
        @(negedge Clock);
        #1;
        checkValue("fk_busy_fall", 64'(Busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        idleInputs();
        applyReset();
        #1;
        checkValue("rst_busy", 64'(Busy), 64'd0);
        checkValue("rst_error", 64'(Error), 64'd0);
        checkValue("rst_evict_empty", 64'(EvictEmpty), 64'd1);
        checkValue("rst_valids", 64'({StoreValid, LoadReady, RefillValid, ChInReady, ChRetValid}), 64'd0);

        // Write on channel 2
        startReq(2'd2, 2'd2);
        doWrite(2, 8);
        writeTail();

        // Read on channel 1 with return backpressure
        doRead(1, 1'b0, 1'b0);

        // PosMap evict/refill
        sendLeaves(32'h10, 16);
        #1;
        checkValue("pm_evict_loaded", 64'(EvictEmpty), 64'd0);
        doPmap(32'h10);
        checkValue("pm_error", 64'(Error), 64'd0);

        // Fake read on channel 3, store side stalled
        doFake();
        checkValue("fk_error", 64'(Error), 64'd0);

        // Load while idle
        @(negedge Clock);
        LoadValid = 1'b1;
        LoadData  = 64'h55;
        #1;
        checkValue("idle_load_ready", 64'(LoadReady), 64'd0);
        @(negedge Clock);
        LoadValid = 1'b0;
        #1;
        checkValue("err_idle_load", 64'(Error), 64'd1);
        repeat (3) @(negedge Clock);
        #1;
        checkValue("err_sticky", 64'(Error), 64'd1);

        applyReset();
        #1;
        checkValue("err_cleared", 64'(Error), 64'd0);

        // Evict overflow: 17th leaf dropped
        sendLeaves(32'h100, 17);
        #1;
        checkValue("err_evict_full", 64'(Error), 64'd1);
        doPmap(32'h100);

        applyReset();
        // SwitchReq during READ is rejected without disturbing the transfer
        doRead(1, 1'b1, 1'b1);

        // Reset mid-write, then a clean full write
        applyReset();
        startReq(2'd2, 2'd0);
        doWrite(0, 3);
        @(negedge Clock);
        Reset     = 1'b0;
        ChInValid = '0;
        #1;
        checkValue("rst_mid_busy", 64'(Busy), 64'd0);
        checkValue("rst_mid_store", 64'(StoreValid), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        startReq(2'd2, 2'd0);
        doWrite(0, 8);
        writeTail();
        checkValue("rst_write_error", 64'(Error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
